ctrl_iload: RTL and testbench

Program loader for the controller instruction memory. It takes instruction words from a narrow host stream, assembles full-width words and writes them sequentially into the instruction RAM. The instruction fetch stage later reads this RAM. Instruction field packing is identical to the fetch stage, MSB to LSB: lstg_f, upse_f, vector_id, result_reg, error_reg, data_uptr, data_lptr, coef_ptr.

---
 rtl/ctrl_iload_pkg.sv | 46 ++++
 rtl/ctrl_iload_asm.sv | 76 +++++++
 rtl/ctrl_iload.sv | 136 +++++++++++++
 tb/tb_ctrl_iload.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_iload_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_iload_pkg
// Shared controller definitions used by the program loader and by the
// instruction fetch stage, so both agree on the instruction word layout.
//   - default field widths
//   - instruction width / beat count helpers
//   - field offsets (MSB to LSB: lstg_f, upse_f, vector_id, result_reg,
//     error_reg, data_uptr, data_lptr, coef_ptr) at the default widths
//   - loader FSM state encoding
// ---------------------------------------------------------------------------
package ctrl_iload_pkg;

    localparam int VIDWIDTH_DEF = 5;
    localparam int RFAWIDTH_DEF = 5;
    localparam int DAWIDTH_DEF  = 12;
    localparam int IAWIDTH_DEF  = 6;
    localparam int BUSWIDTH_DEF = 16;

    function automatic int instr_width(input int vid_w, input int rfa_w, input int da_w);
        return 2 + vid_w + 2 * rfa_w + 3 * da_w;
    endfunction

    function automatic int nbeats(input int instr_w, input int bus_w);
        return (instr_w + bus_w - 1) / bus_w;
    endfunction

    localparam int INSTRWIDTH_DEF = instr_width(VIDWIDTH_DEF, RFAWIDTH_DEF, DAWIDTH_DEF);

    // Field offsets at the default widths (LSB positions, single-bit flags by position)
    localparam int CP_LSB   = 0;
    localparam int DL_LSB   = CP_LSB  + DAWIDTH_DEF;
    localparam int DU_LSB   = DL_LSB  + DAWIDTH_DEF;
    localparam int ERR_LSB  = DU_LSB  + DAWIDTH_DEF;
    localparam int RES_LSB  = ERR_LSB + RFAWIDTH_DEF;
    localparam int VID_LSB  = RES_LSB + RFAWIDTH_DEF;
    localparam int UPSE_POS = VID_LSB + VIDWIDTH_DEF;
    localparam int LSTG_POS = UPSE_POS + 1;

    // Loader FSM encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ctrl_iload_asm.sv
// ---------------------------------------------------------------------------
// ctrl_iload_asm
// Chunk-to-word assembler. Places accepted host chunks, least-significant
// chunk first, into an instruction-wide register and flags any nonzero bit
// that falls beyond the instruction width.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   clr            restart assembly: beat, partial word and pad flag to 0
//   accept         a chunk is transferred this cycle
//   s_data         host chunk
//   word_full      assembled word including the chunk accepted this cycle
//   last_beat      strobe: this accept completes the word
//   pad_err        sticky nonzero-padding flag (registered)
// ---------------------------------------------------------------------------
module ctrl_iload_asm
    import ctrl_iload_pkg::*;
#(
    parameter  int INSTRWIDTH = INSTRWIDTH_DEF,
    parameter  int BUSWIDTH   = BUSWIDTH_DEF,
    localparam int NBEATS     = nbeats(INSTRWIDTH, BUSWIDTH),
    localparam int BEATW      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  accept,
    input  logic [BUSWIDTH-1:0]   s_data,
    output logic [INSTRWIDTH-1:0] word_full,
    output logic                  last_beat,
    output logic                  pad_err
);

    logic [BEATW-1:0]      beat_reg;
    logic [INSTRWIDTH-1:0] asm_reg;
    logic                  pad_reg;
    logic [NBEATS-1:0]     pad_hit;

    // One lane per beat; the top lane may be narrower than the bus, and the
    // chunk bits that do not fit are only inspected for the pad flag.
    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
            localparam int LO = gi * BUSWIDTH;
            localparam int W  = (INSTRWIDTH - LO < BUSWIDTH) ? (INSTRWIDTH - LO) : BUSWIDTH;
            logic sel;
            assign sel = accept && (beat_reg == BEATW'(gi));
            assign word_full[LO +: W] = sel ? s_data[W-1:0] : asm_reg[LO +: W];
            if (W < BUSWIDTH) begin : g_pad
                assign pad_hit[gi] = sel && (|s_data[BUSWIDTH-1:W]);
            end else begin : g_nopad
                assign pad_hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign last_beat = accept && (beat_reg == BEATW'(NBEATS - 1));
    assign pad_err   = pad_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_reg <= '0;
            asm_reg  <= '0;
            pad_reg  <= 1'b0;
        end else if (clr) begin
            beat_reg <= '0;
            asm_reg  <= '0;
            pad_reg  <= 1'b0;
        end else if (accept) begin
            asm_reg  <= word_full;
            beat_reg <= last_beat ? '0 : beat_reg + BEATW'(1);
            if (|pad_hit) begin
                pad_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_iload.sv
// ---------------------------------------------------------------------------
// ctrl_iload
// Program loader for the controller instruction RAM. Assembles instruction
// words from a narrow host stream and writes them to consecutive addresses
// starting at 0.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   start        load request (only honoured while idle)
//   instr_cnt    instructions to load, latched on start, clamped to 2^IAWIDTH
//   s_data/s_valid/s_ready   host chunk stream, LS chunk first
//   imem_we/imem_addr/imem_wdata   instruction RAM write port
//   busy         high whenever not idle
//   done         one-cycle completion pulse
//   pad_err      sticky: nonzero bit received beyond the instruction width
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ctrl_iload
    import ctrl_iload_pkg::*;
#(
    parameter  int VIDWIDTH   = VIDWIDTH_DEF,
    parameter  int RFAWIDTH   = RFAWIDTH_DEF,
    parameter  int DAWIDTH    = DAWIDTH_DEF,
    parameter  int IAWIDTH    = IAWIDTH_DEF,
    parameter  int BUSWIDTH   = BUSWIDTH_DEF,
    localparam int INSTRWIDTH = instr_width(VIDWIDTH, RFAWIDTH, DAWIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IAWIDTH:0]      instr_cnt,
    input  logic [BUSWIDTH-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [IAWIDTH-1:0]    imem_addr,
    output logic [INSTRWIDTH-1:0] imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pad_err
);

    localparam logic [IAWIDTH:0] MAXCNT  = {1'b1, {IAWIDTH{1'b0}}};
    localparam logic [IAWIDTH:0] CNT_ONE = (IAWIDTH+1)'(1);

    state_t                state_reg, state_next;
    logic [IAWIDTH:0]      cnt_reg;
    logic [IAWIDTH-1:0]    addr_reg;
    logic                  s_ready_reg;
    logic                  imem_we_reg;
    logic [IAWIDTH-1:0]    imem_addr_reg;
    logic [INSTRWIDTH-1:0] imem_wdata_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  start_acc;
    logic                  accept;
    logic                  last_beat;
    logic                  is_last;
    logic [IAWIDTH:0]      cnt_clamped;
    logic [INSTRWIDTH-1:0] word_full;

    assign start_acc   = (state_reg == ST_IDLE) && start;
    // s_ready_reg is high exactly while in LOAD, so it doubles as the state qualifier
    assign accept      = s_valid && s_ready_reg;
    assign cnt_clamped = (instr_cnt > MAXCNT) ? MAXCNT : instr_cnt;
    assign is_last     = ({1'b0, addr_reg} == (cnt_reg - CNT_ONE));

    ctrl_iload_asm #(
        .INSTRWIDTH (INSTRWIDTH),
        .BUSWIDTH   (BUSWIDTH)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .accept     (accept),
        .s_data     (s_data),
        .word_full  (word_full),
        .last_beat  (last_beat),
        .pad_err    (pad_err)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (instr_cnt == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (last_beat) state_next = ST_WRITE;
            ST_WRITE: state_next = is_last ? ST_DONE : ST_LOAD;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            s_ready_reg    <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            // Output flags are decoded from the next state so they line up
            // with the state they describe.
            s_ready_reg <= (state_next == ST_LOAD);
            imem_we_reg <= (state_next == ST_WRITE);
            busy_reg    <= (state_next != ST_IDLE);
            done_reg    <= (state_next == ST_DONE);

            if (start_acc) begin
                cnt_reg  <= cnt_clamped;
                addr_reg <= '0;
            end else if ((state_reg == ST_WRITE) && !is_last) begin
                addr_reg <= addr_reg + IAWIDTH'(1);
            end

            // Capture the word on the final handshake so it is presented
            // together with imem_we in the following cycle.
            if (last_beat) begin
                imem_wdata_reg <= word_full;
                imem_addr_reg  <= addr_reg;
            end
        end
    end

    assign s_ready    = s_ready_reg;
    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_ctrl_iload.sv
// ---------------------------------------------------------------------------
// tb_ctrl_iload
// Directed bench for the program loader: a table of single-instruction loads
// with hand-computed words, plus sequences for multi-word, empty, aborted,
// stalled and clamped loads.
// ---------------------------------------------------------------------------
module tb_ctrl_iload;
    import ctrl_iload_pkg::*;

    localparam int IAW = IAWIDTH_DEF;
    localparam int BW  = BUSWIDTH_DEF;
    localparam int IW  = INSTRWIDTH_DEF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [IAW:0]   instr_cnt = '0;
    logic [BW-1:0]  s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic           imem_we;
    logic [IAW-1:0] imem_addr;
    logic [IW-1:0]  imem_wdata;
    logic           busy;
    logic           done;
    logic           pad_err;

    always #5 clk = ~clk;

    ctrl_iload dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_cnt  (instr_cnt),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .pad_err    (pad_err)
    );

    typedef struct {
        logic [63:0]   chunks;   // chunk k at [k*16 +: 16]
        logic [IW-1:0] word;
        logic          pad;
    } vec_t;

    vec_t vt[5];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int            we_cyc[$];
    int            we_addr[$];
    logic [IW-1:0] we_data[$];
    int            done_cyc[$];
    logic [BW-1:0] chunk_q[$];
    int            busy_cnt, rdy_cnt, start_cyc;
    bit            timed_out;
    logic          pad_after_start, post_busy, post_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Advance one clock and log the registered outputs 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (imem_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(int'(imem_addr));
            we_data.push_back(imem_wdata);
        end
        if (done)    done_cyc.push_back(cyc);
        if (s_ready) rdy_cnt++;
        if (busy)    busy_cnt++;
    endtask

    function automatic logic [IW-1:0] model_word(input int i);
        logic [63:0] w;
        w = {chunk_q[4*i+3], chunk_q[4*i+2], chunk_q[4*i+1], chunk_q[4*i]};
        return w[IW-1:0];
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_we"},      64'(imem_we), 64'd0);
        chk({tag, "_addr"},    64'(imem_addr), 64'd0);
        chk({tag, "_wdata"},   64'(imem_wdata), 64'd0);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_done"},    64'(done), 64'd0);
        chk({tag, "_pad"},     64'(pad_err), 64'd0);
    endtask

    // Run one load from chunk_q. stall: s_valid follows 1,0,0 per cycle.
    // extra: pulse start (instr_cnt=0) while busy. abort_at>=0: drop rst after
    // that many handshakes and return.
    task automatic run_load(input int cnt, input bit stall, input bit extra, input int abort_at);
        int idx = 0;
        int k = 0;
        int guard = 0;
        bit hs;
        we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
        busy_cnt = 0; rdy_cnt = 0; timed_out = 0;
        instr_cnt = (IAW+1)'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        instr_cnt = '0;
        start_cyc = cyc;
        pad_after_start = pad_err;
        while (done_cyc.size() == 0) begin
            if (guard++ > 3000) begin
                timed_out = 1;
                break;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b0;
                s_valid = 1'b0;
                tick();
                rst = 1'b1;
                return;
            end
            s_valid = stall ? (k % 3 == 0) : 1'b1;
            if (idx >= chunk_q.size()) s_valid = 1'b0;
            s_data = s_valid ? chunk_q[idx] : 16'hFFFF;
            if (extra && busy && (k % 7 == 3)) begin
                start = 1'b1;
                instr_cnt = '0;
            end else begin
                start = 1'b0;
            end
            hs = s_valid && s_ready;
            tick();
            if (hs) idx++;
            k++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        s_data = '0;
        tick();
        post_busy = busy;
        post_done = done;
    endtask

    initial begin
        vt[0] = '{64'h0004_0003_0002_0001, 53'h4_0003_0002_0001, 1'b0};
        vt[1] = '{64'h001F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF, 1'b0};
        vt[2] = '{64'h8000_9ABC_5678_1234, 53'h9ABC_5678_1234, 1'b1};
        vt[3] = '{64'h0020_0000_0000_0000, 53'h0, 1'b1};
        vt[4] = '{64'h0010_0F0F_5A5A_A5A5, 53'h10_0F0F_5A5A_A5A5, 1'b0};

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b1;
        tick();

        // Table of single-instruction loads
        for (int i = 0; i < 5; i++) begin
            chunk_q.delete();
            for (int c = 0; c < 4; c++) chunk_q.push_back(vt[i].chunks[c*16 +: 16]);
            run_load(1, 1'b0, 1'b0, -1);
            chk($sformatf("v%0d_timeout", i), 64'(timed_out), 64'd0);
            chk($sformatf("v%0d_pad_clr", i), 64'(pad_after_start), 64'd0);
            chk($sformatf("v%0d_we_cnt", i), 64'(we_cyc.size()), 64'd1);
            if (we_cyc.size() > 0) begin
                chk($sformatf("v%0d_addr", i), 64'(we_addr[0]), 64'd0);
                chk($sformatf("v%0d_wdata", i), 64'(we_data[0]), 64'(vt[i].word));
                chk($sformatf("v%0d_we_lat", i), 64'(we_cyc[0] - start_cyc), 64'd4);
            end
            chk($sformatf("v%0d_done_cnt", i), 64'(done_cyc.size()), 64'd1);
            if (done_cyc.size() > 0 && we_cyc.size() > 0)
                chk($sformatf("v%0d_done_lat", i), 64'(done_cyc[0] - we_cyc[0]), 64'd1);
            chk($sformatf("v%0d_pad", i), 64'(pad_err), 64'(vt[i].pad));
            chk($sformatf("v%0d_idle_busy", i), 64'(post_busy), 64'd0);
        end

        // Three instructions back to back
        chunk_q.delete();
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 4; c++)
                chunk_q.push_back((c == 3) ? 16'(i + 1) : 16'(16'h1000 * (i + 1) + 16'h0101 * c));
        run_load(3, 1'b0, 1'b0, -1);
        chk("b2b_timeout", 64'(timed_out), 64'd0);
        chk("b2b_we_cnt", 64'(we_cyc.size()), 64'd3);
        for (int j = 0; j < 3 && j < we_cyc.size(); j++) begin
            chk($sformatf("b2b_addr%0d", j), 64'(we_addr[j]), 64'(j));
            chk($sformatf("b2b_wdata%0d", j), 64'(we_data[j]), 64'(model_word(j)));
            if (j > 0) chk($sformatf("b2b_gap%0d", j), 64'(we_cyc[j] - we_cyc[j-1]), 64'd5);
        end
        chk("b2b_done_cnt", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) begin
            chk("b2b_busy_all", 64'(busy_cnt), 64'(done_cyc[0] - start_cyc + 1));
            if (we_cyc.size() > 0)
                chk("b2b_done_lat", 64'(done_cyc[0] - we_cyc[we_cyc.size()-1]), 64'd1);
        end
        chk("b2b_idle_busy", 64'(post_busy), 64'd0);
        chk("b2b_idle_done", 64'(post_done), 64'd0);

        // Empty load
        chunk_q.delete();
        run_load(0, 1'b0, 1'b0, -1);
        chk("zero_we_cnt", 64'(we_cyc.size()), 64'd0);
        chk("zero_done_cnt", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() > 0) chk("zero_done_at", 64'(done_cyc[0] - start_cyc), 64'd0);
        chk("zero_busy_cnt", 64'(busy_cnt), 64'd1);
        chk("zero_rdy_cnt", 64'(rdy_cnt), 64'd0);

        // Reset during the second instruction of a two-instruction load
        chunk_q.delete();
        for (int c = 0; c < 8; c++) chunk_q.push_back(16'(16'h0F00 + c));
        run_load(2, 1'b0, 1'b0, 6);
        chk("abort_we_cnt", 64'(we_cyc.size()), 64'd1);
        if (we_cyc.size() > 0) chk("abort_addr", 64'(we_addr[0]), 64'd0);
        chk("abort_done_cnt", 64'(done_cyc.size()), 64'd0);
        chk_zero("abort");
        chunk_q.delete();
        for (int c = 0; c < 4; c++) chunk_q.push_back(vt[0].chunks[c*16 +: 16]);
        run_load(1, 1'b0, 1'b0, -1);
        chk("reload_we_cnt", 64'(we_cyc.size()), 64'd1);
        if (we_cyc.size() > 0) begin
            chk("reload_addr", 64'(we_addr[0]), 64'd0);
            chk("reload_wdata", 64'(we_data[0]), 64'(vt[0].word));
        end

        // Stalled host plus start pulses while busy
        chunk_q.delete();
        chunk_q.push_back(16'h1111); chunk_q.push_back(16'h2222);
        chunk_q.push_back(16'h3333); chunk_q.push_back(16'h8015);
        chunk_q.push_back(16'hAAAA); chunk_q.push_back(16'hBBBB);
        chunk_q.push_back(16'hCCCC); chunk_q.push_back(16'h000C);
        run_load(2, 1'b1, 1'b1, -1);
        chk("stall_timeout", 64'(timed_out), 64'd0);
        chk("stall_we_cnt", 64'(we_cyc.size()), 64'd2);
        if (we_cyc.size() > 1) begin
            chk("stall_addr0", 64'(we_addr[0]), 64'd0);
            chk("stall_addr1", 64'(we_addr[1]), 64'd1);
            chk("stall_wdata0", 64'(we_data[0]), 64'h15_3333_2222_1111);
            chk("stall_wdata1", 64'(we_data[1]), 64'h0C_CCCC_BBBB_AAAA);
        end
        chk("stall_done_cnt", 64'(done_cyc.size()), 64'd1);
        chk("stall_pad", 64'(pad_err), 64'd1);

        // Oversized count clamps to the full RAM
        chunk_q.delete();
        for (int c = 0; c < 256; c++)
            chunk_q.push_back((c % 4 == 3) ? 16'(c % 32) : 16'(c * 37));
        run_load(100, 1'b0, 1'b0, -1);
        chk("clamp_timeout", 64'(timed_out), 64'd0);
        chk("clamp_we_cnt", 64'(we_cyc.size()), 64'd64);
        if (we_cyc.size() == 64) begin
            chk("clamp_addr_first", 64'(we_addr[0]), 64'd0);
            chk("clamp_addr_last", 64'(we_addr[63]), 64'd63);
            chk("clamp_wdata_last", 64'(we_data[63]), 64'(model_word(63)));
        end
        chk("clamp_done_cnt", 64'(done_cyc.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
